// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: registered state, combinational control strobes,
// plus free-running cycle and retired-instruction counters.
module multicycle_control_unit #(
    parameter int CNT_W   = 32,
    parameter bit WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal_instr,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_ILLEGAL  = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] cycle_cnt_reg, instret_cnt_reg;
    logic             rdy;

    // With waits disabled every memory access completes in its first cycle.
    assign rdy = WAIT_EN ? mem_ready : 1'b1;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_bit);
        case (f3)
            3'b000:  alu_decode = sub_bit ? ALU_SUB : ALU_ADD;
            3'b010:  alu_decode = ALU_SLT;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        state_next    = state_reg;
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        AdrSrc        = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ImmSrc        = 2'b00;
        ALUControl    = ALU_ADD;
        illegal_instr = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                PCWrite   = rdy;
                if (rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = (opcode == OP_STORE) ? 2'b01 : 2'b00;
                state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (rdy) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (rdy) state_next = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7_5);
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, 1'b0);
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            // ILLEGAL and unused codes park here until reset.
            default: begin
                illegal_instr = 1'b1;
                state_next    = S_ILLEGAL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_FETCH;
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            // An instruction retires whenever control returns to FETCH.
            if (state_next == S_FETCH && state_reg != S_FETCH)
                instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
        end
    end

    assign state_o     = state_reg;
    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit, plus hand sequences for
// illegal parking, asynchronous reset, WAIT_EN=0 and a narrow counter wrap.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic        mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, illegal_instr;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt, instret_cnt;

    logic        n_mem_req, n_MemWrite, n_IRWrite, n_PCWrite, n_RegWrite, n_AdrSrc, n_illegal;
    logic [1:0]  n_ALUSrcA, n_ALUSrcB, n_ResultSrc, n_ImmSrc;
    logic [2:0]  n_ALUControl;
    logic [3:0]  n_state, n_cycle, n_instret;

    multicycle_control_unit #(.CNT_W(32), .WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal_instr(illegal_instr), .state_o(state_o),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    multicycle_control_unit #(.CNT_W(4), .WAIT_EN(1'b0)) dut_narrow (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(n_mem_req), .MemWrite(n_MemWrite),
        .IRWrite(n_IRWrite), .PCWrite(n_PCWrite), .RegWrite(n_RegWrite), .AdrSrc(n_AdrSrc),
        .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ResultSrc(n_ResultSrc), .ImmSrc(n_ImmSrc),
        .ALUControl(n_ALUControl), .illegal_instr(n_illegal), .state_o(n_state),
        .cycle_cnt(n_cycle), .instret_cnt(n_instret)
    );

    always #5 clk = ~clk;

    // Packed control word: mem_req MemWrite IRWrite PCWrite RegWrite AdrSrc
    //                      ALUSrcA ALUSrcB ResultSrc ImmSrc ALUControl illegal_instr
    logic [17:0] ctrl;
    assign ctrl = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal_instr};

    localparam logic [17:0] C_FETCH   = 18'b1_0_1_1_0_0_00_10_10_00_000_0;
    localparam logic [17:0] C_FSTALL  = 18'b1_0_0_0_0_0_00_10_10_00_000_0;
    localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_01_01_00_10_000_0;
    localparam logic [17:0] C_ADR_LD  = 18'b0_0_0_0_0_0_10_01_00_00_000_0;
    localparam logic [17:0] C_ADR_ST  = 18'b0_0_0_0_0_0_10_01_00_01_000_0;
    localparam logic [17:0] C_MEMRD   = 18'b1_0_0_0_0_1_00_00_00_00_000_0;
    localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_1_0_00_00_01_00_000_0;
    localparam logic [17:0] C_MEMWR   = 18'b1_1_0_0_0_1_00_00_00_00_000_0;
    localparam logic [17:0] C_EXR_SUB = 18'b0_0_0_0_0_0_10_00_00_00_001_0;
    localparam logic [17:0] C_EXR_OR  = 18'b0_0_0_0_0_0_10_00_00_00_011_0;
    localparam logic [17:0] C_EXI_ADD = 18'b0_0_0_0_0_0_10_01_00_00_000_0;
    localparam logic [17:0] C_ALUWB   = 18'b0_0_0_0_1_0_00_00_00_00_000_0;
    localparam logic [17:0] C_BEQ_T   = 18'b0_0_0_1_0_0_10_00_00_00_001_0;
    localparam logic [17:0] C_BEQ_N   = 18'b0_0_0_0_0_0_10_00_00_00_001_0;
    localparam logic [17:0] C_JAL     = 18'b0_0_0_1_0_0_01_10_00_00_000_0;
    localparam logic [17:0] C_ILLEGAL = 18'b0_0_0_0_0_0_00_00_00_00_000_1;

    localparam logic [6:0] LW  = 7'b0000011, SW  = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011, BR  = 7'b1100011, JL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] cw;
        int          ir;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic [17:0] cw, input int ir);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.st = st; v.cw = cw; v.ir = ir;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int base;

    initial begin
        // lw, no wait
        add(LW, 3'b010, 0, 0, 1, 4'd0, C_FETCH,   0);
        add(LW, 3'b010, 0, 0, 1, 4'd1, C_DECODE,  0);
        add(LW, 3'b010, 0, 0, 1, 4'd2, C_ADR_LD,  0);
        add(LW, 3'b010, 0, 0, 1, 4'd3, C_MEMRD,   0);
        add(LW, 3'b010, 0, 0, 1, 4'd4, C_MEMWB,   0);
        // R-type sub
        add(RT, 3'b000, 1, 0, 1, 4'd0, C_FETCH,   1);
        add(RT, 3'b000, 1, 0, 1, 4'd1, C_DECODE,  1);
        add(RT, 3'b000, 1, 0, 1, 4'd6, C_EXR_SUB, 1);
        add(RT, 3'b000, 1, 0, 1, 4'd8, C_ALUWB,   1);
        // jal
        add(JL, 3'b000, 0, 0, 1, 4'd0, C_FETCH,   2);
        add(JL, 3'b000, 0, 0, 1, 4'd1, C_DECODE,  2);
        add(JL, 3'b000, 0, 0, 1, 4'd10, C_JAL,    2);
        add(JL, 3'b000, 0, 0, 1, 4'd8, C_ALUWB,   2);
        // beq taken, then not taken
        add(BR, 3'b000, 0, 1, 1, 4'd0, C_FETCH,   3);
        add(BR, 3'b000, 0, 1, 1, 4'd1, C_DECODE,  3);
        add(BR, 3'b000, 0, 1, 1, 4'd9, C_BEQ_T,   3);
        add(BR, 3'b000, 0, 0, 1, 4'd0, C_FETCH,   4);
        add(BR, 3'b000, 0, 0, 1, 4'd1, C_DECODE,  4);
        add(BR, 3'b000, 0, 0, 1, 4'd9, C_BEQ_N,   4);
        // addi with funct7_5 set must still add
        add(IT, 3'b000, 1, 0, 1, 4'd0, C_FETCH,   5);
        add(IT, 3'b000, 1, 0, 1, 4'd1, C_DECODE,  5);
        add(IT, 3'b000, 1, 0, 1, 4'd7, C_EXI_ADD, 5);
        add(IT, 3'b000, 1, 0, 1, 4'd8, C_ALUWB,   5);
        // R-type or
        add(RT, 3'b110, 0, 0, 1, 4'd0, C_FETCH,   6);
        add(RT, 3'b110, 0, 0, 1, 4'd1, C_DECODE,  6);
        add(RT, 3'b110, 0, 0, 1, 4'd6, C_EXR_OR,  6);
        add(RT, 3'b110, 0, 0, 1, 4'd8, C_ALUWB,   6);
        // sw with a fetch stall and three wait cycles in MEMWRITE
        add(SW, 3'b010, 0, 0, 0, 4'd0, C_FSTALL,  7);
        add(SW, 3'b010, 0, 0, 1, 4'd0, C_FETCH,   7);
        add(SW, 3'b010, 0, 0, 1, 4'd1, C_DECODE,  7);
        add(SW, 3'b010, 0, 0, 1, 4'd2, C_ADR_ST,  7);
        add(SW, 3'b010, 0, 0, 0, 4'd5, C_MEMWR,   7);
        add(SW, 3'b010, 0, 0, 0, 4'd5, C_MEMWR,   7);
        add(SW, 3'b010, 0, 0, 0, 4'd5, C_MEMWR,   7);
        add(SW, 3'b010, 0, 0, 1, 4'd5, C_MEMWR,   7);
        // undefined opcode
        add(BAD, 3'b000, 0, 0, 1, 4'd0, C_FETCH,  8);
        add(BAD, 3'b000, 0, 0, 1, 4'd1, C_DECODE, 8);

        repeat (2) @(negedge clk);
        #1;
        check("reset_state",   32'(state_o),  32'd0);
        check("reset_cycle",   cycle_cnt,     32'd0);
        check("reset_instret", instret_cnt,   32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op; funct3 = vecs[i].f3; funct7_5 = vecs[i].f7;
            zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            check($sformatf("v%0d_state", i),   32'(state_o), 32'(vecs[i].st));
            check($sformatf("v%0d_ctrl", i),    32'(ctrl),    32'(vecs[i].cw));
            check($sformatf("v%0d_instret", i), instret_cnt,  32'(vecs[i].ir));
            check($sformatf("v%0d_cycle", i),   cycle_cnt,    32'(i));
            @(negedge clk);
        end

        // Parked in ILLEGAL while the cycle counter keeps running
        base = vecs.size();
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("ill%0d_state", k), 32'(state_o),       32'd11);
            check($sformatf("ill%0d_flag", k),  32'(illegal_instr), 32'd1);
            check($sformatf("ill%0d_cycle", k), cycle_cnt,          32'(base + k));
            @(negedge clk);
        end

        // Asynchronous reset out of ILLEGAL, mid-cycle
        #2 rst = 1'b1;
        #1;
        check("rst_ill_state",   32'(state_o),       32'd0);
        check("rst_ill_cycle",   cycle_cnt,          32'd0);
        check("rst_ill_instret", instret_cnt,        32'd0);
        check("rst_ill_flag",    32'(illegal_instr), 32'd0);

        // Reset arriving during a stalled store drops MemWrite at once
        @(negedge clk);
        rst = 1'b0; opcode = SW; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("sw_abort_pre_state", 32'(state_o),  32'd5);
        check("sw_abort_pre_mw",    32'(MemWrite), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("sw_abort_mw",    32'(MemWrite), 32'd0);
        check("sw_abort_state", 32'(state_o),  32'd0);
        check("sw_abort_cycle", cycle_cnt,     32'd0);

        // Narrow instance: no memory waits and a 4-bit counter wrap
        @(negedge clk);
        rst = 1'b0; opcode = LW; funct3 = 3'b010; mem_ready = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            #1;
            check($sformatf("nw%0d_cycle", k), 32'(n_cycle), 32'(k % 16));
            if (k < 6) begin
                logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
                check($sformatf("nw%0d_state", k), 32'(n_state), 32'(seq[k]));
            end
            if (k == 6)
                check("nw_instret", 32'(n_instret), 32'd1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the cycle and retired-instruction counters.
REQ-002 SHALL have parameter WAIT_EN, default 1; 1 = honour mem_ready, 0 = treat mem_ready as constant 1.
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port opcode  input  7  instruction[6:0] from the instruction register.
REQ-006 SHALL have port funct3  input  3  instruction[14:12].
REQ-007 SHALL have port funct7_5  input  1  instruction[30].
REQ-008 SHALL have port zero  input  1  ALU zero flag.
REQ-009 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-010 SHALL have port mem_req  output  1  memory access request.
REQ-011 SHALL have port MemWrite  output  1  store strobe.
REQ-012 SHALL have ports IRWrite, PCWrite, RegWrite, AdrSrc  output  1 each  (AdrSrc: 0 = PC, 1 = Result).
REQ-013 SHALL have ports ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  output  2 each.
REQ-014 SHALL have port ALUControl  output  3  (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-015 SHALL have ports illegal_instr  output  1, state_o  output  4, cycle_cnt and instret_cnt  output  CNT_W.

Function
REQ-016 SHALL encode state_o as: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, ILLEGAL 11.
REQ-017 SHALL use these encodings: ALUSrcA 00 PC, 01 OldPC, 10 RD1; ALUSrcB 00 RD2, 01 ImmExt, 10 const 4; ResultSrc 00 ALUOut, 01 Data, 10 ALUResult; ImmSrc 00 I, 01 S, 10 B, 11 J.
REQ-018 SHALL drive all unlisted outputs to 0 in every state.
REQ-019 SHALL in FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10; IRWrite=PCWrite=mem_ready; next DECODE if mem_ready, else stay.
REQ-020 SHALL in DECODE: ALUSrcA=01, ALUSrcB=01, add, ImmSrc=10; next state by opcode: 0000011/0100011 MEMADR, 0110011 EXECUTER, 0010011 EXECUTEI, 1100011 with funct3=000 BEQ, 1101111 JAL, anything else ILLEGAL.
REQ-021 SHALL in MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=01 for store else 00; next MEMREAD for load, MEMWRITE for store.
REQ-022 SHALL in MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; next MEMWB on mem_ready, else stay.
REQ-023 SHALL in MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-024 SHALL in MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00, held for the whole wait; next FETCH on mem_ready.
REQ-025 SHALL in EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUControl decoded from funct3/funct7_5 (000 with funct7_5=1 sub, else add; 010 slt; 110 or; 111 and; others add); next ALUWB.
REQ-026 SHALL in EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUControl decoded as in REQ-025 with funct7_5 ignored; next ALUWB.
REQ-027 SHALL in ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-028 SHALL in BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero; next FETCH.
REQ-029 SHALL in JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-030 SHALL in ILLEGAL: illegal_instr=1, all strobes 0; remain until rst.
REQ-031 SHALL increment cycle_cnt every clock edge outside reset, including ILLEGAL, wrapping from all-ones to 0.
REQ-032 SHALL increment instret_cnt by 1 on each edge where the next state is FETCH and the current state is not FETCH, wrapping modulo 2^CNT_W.
REQ-033 SHALL, with WAIT_EN=0, leave FETCH, MEMREAD and MEMWRITE after exactly one cycle.
REQ-034 SHALL have a registered state only; all outputs except the counters are combinational from state and inputs.

Reset
REQ-035 SHALL, while rst=1, force state FETCH and cycle_cnt=instret_cnt=0 immediately, independent of clk.
REQ-036 SHALL abort any in-progress access on rst mid-operation; MemWrite drops asynchronously with the state change.
REQ-037 SHALL, on the first edge after rst deasserts, have cycle_cnt=1 and state per the REQ-019 decision.

Verification
REQ-038 SHALL test lw with mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; instret_cnt=1 after 5 cycles.
REQ-039 SHALL test sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-040 SHALL test beq with zero=1, then with zero=0 -> PCWrite=1 in BEQ for the first, 0 for the second; 3 cycles each.
REQ-041 SHALL test R-type sub (funct3=000, funct7_5=1) -> ALUControl=001 in EXECUTER; JAL -> states 0,1,10,8,0.
REQ-042 SHALL test opcode 1111111 -> ILLEGAL, illegal_instr=1 held 10 cycles with cycle_cnt still counting; rst -> state 0, counters 0.
REQ-043 SHALL test CNT_W=4 -> cycle_cnt wraps 15 -> 0.
